// File: rtl/mod_phase_sequencer.sv
// Multi-phase time-of-flight capture sequencer: drives FREQ/PHASE/DUTY selects and the
// pixel drain for mod_signal_gen through DRAIN -> EXPOSE -> READOUT per phase step.
module mod_phase_sequencer #(
  parameter int CNT_W    = 24,
  parameter int AUX_W    = 16,
  parameter int FREQ_MAX = 5
) (
  input  logic             USER_CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ABORT,
  input  logic [4:0]       PHASE_START,
  input  logic [4:0]       PHASE_STEP,
  input  logic [3:0]       NUM_PHASES,
  input  logic [AUX_W-1:0] DRAIN_CYCLES,
  input  logic [CNT_W-1:0] EXPOSE_CYCLES,
  input  logic [AUX_W-1:0] READOUT_CYCLES,
  input  logic [2:0]       FREQ_REQ,
  input  logic [3:0]       DUTY_REQ,
  output logic [2:0]       FREQ_SEL,
  output logic [4:0]       PHASE_SEL,
  output logic [3:0]       DUTY_SEL,
  output logic             DRAIN_B,
  output logic             MOD_EN,
  output logic             READOUT_REQ,
  output logic             BUSY,
  output logic             DONE,
  output logic [3:0]       PHASE_IDX
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    EXPOSE  = 2'd2,
    READOUT = 2'd3
  } state_t;

  localparam logic [2:0] FREQ_MAX_C = 3'(FREQ_MAX);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       last_idx_q;
  logic [4:0]       step_q;
  logic [AUX_W-1:0] drain_m1_q;
  logic [CNT_W-1:0] exp_m1_q;
  logic [AUX_W-1:0] ro_m1_q;

  logic [2:0]       freq_q;
  logic [4:0]       phase_q;
  logic [3:0]       duty_q;
  logic             drain_b_q;
  logic             mod_en_q;
  logic             ro_req_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       idx_q;

  // Lengths are held as (length - 1) so a zero request collapses to a single cycle.
  logic [AUX_W-1:0] drain_m1_d;
  logic [CNT_W-1:0] exp_m1_d;
  logic [AUX_W-1:0] ro_m1_d;
  logic [3:0]       last_idx_d;
  logic [2:0]       freq_d;
  logic             cnt_zero;

  assign drain_m1_d = (DRAIN_CYCLES == '0)   ? '0 : DRAIN_CYCLES - AUX_W'(1);
  assign exp_m1_d   = (EXPOSE_CYCLES == '0)  ? '0 : EXPOSE_CYCLES - CNT_W'(1);
  assign ro_m1_d    = (READOUT_CYCLES == '0) ? '0 : READOUT_CYCLES - AUX_W'(1);
  assign last_idx_d = (NUM_PHASES == 4'd0)   ? 4'd0 : NUM_PHASES - 4'd1;
  assign freq_d     = (FREQ_REQ > FREQ_MAX_C) ? FREQ_MAX_C : FREQ_REQ;
  assign cnt_zero   = (cnt_q == '0);

  always_ff @(posedge USER_CLOCK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_idx_q <= '0;
      step_q     <= '0;
      drain_m1_q <= '0;
      exp_m1_q   <= '0;
      ro_m1_q    <= '0;
      freq_q     <= '0;
      phase_q    <= '0;
      duty_q     <= '0;
      drain_b_q  <= 1'b0;
      mod_en_q   <= 1'b0;
      ro_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (ABORT) begin
        // Selects and step index are left as-is so the host can see where it stopped.
        state_q   <= IDLE;
        drain_b_q <= 1'b0;
        mod_en_q  <= 1'b0;
        ro_req_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (START) begin
              last_idx_q <= last_idx_d;
              step_q     <= PHASE_STEP;
              drain_m1_q <= drain_m1_d;
              exp_m1_q   <= exp_m1_d;
              ro_m1_q    <= ro_m1_d;
              freq_q     <= freq_d;
              duty_q     <= DUTY_REQ;
              phase_q    <= PHASE_START;
              idx_q      <= 4'd0;
              cnt_q      <= CNT_W'(drain_m1_d);
              state_q    <= DRAIN;
              busy_q     <= 1'b1;
              drain_b_q  <= 1'b0;
            end
          end
          DRAIN: begin
            if (cnt_zero) begin
              state_q   <= EXPOSE;
              cnt_q     <= exp_m1_q;
              drain_b_q <= 1'b1;
              mod_en_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          EXPOSE: begin
            if (cnt_zero) begin
              state_q  <= READOUT;
              cnt_q    <= CNT_W'(ro_m1_q);
              mod_en_q <= 1'b0;
              ro_req_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          READOUT: begin
            if (cnt_zero) begin
              ro_req_q  <= 1'b0;
              drain_b_q <= 1'b0;
              if (idx_q == last_idx_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                // Phase only moves on DRAIN entry so the generator re-aligns while drained.
                idx_q   <= idx_q + 4'd1;
                phase_q <= phase_q + step_q;
                cnt_q   <= CNT_W'(drain_m1_q);
                state_q <= DRAIN;
              end
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign FREQ_SEL    = freq_q;
  assign PHASE_SEL   = phase_q;
  assign DUTY_SEL    = duty_q;
  assign DRAIN_B     = drain_b_q;
  assign MOD_EN      = mod_en_q;
  assign READOUT_REQ = ro_req_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign PHASE_IDX   = idx_q;

endmodule

// File: tb/tb_mod_phase_sequencer.sv
// Bench for mod_phase_sequencer: table vectors, hand-written abort/reset sequences and
// randomized captures compared cycle by cycle against a per-step trace model.
module tb_mod_phase_sequencer;

  logic        clk;
  logic        RESET, START, ABORT;
  logic [4:0]  PHASE_START, PHASE_STEP;
  logic [3:0]  NUM_PHASES;
  logic [15:0] DRAIN_CYCLES, READOUT_CYCLES;
  logic [23:0] EXPOSE_CYCLES;
  logic [2:0]  FREQ_REQ;
  logic [3:0]  DUTY_REQ;
  logic [2:0]  FREQ_SEL;
  logic [4:0]  PHASE_SEL;
  logic [3:0]  DUTY_SEL;
  logic        DRAIN_B, MOD_EN, READOUT_REQ, BUSY, DONE;
  logic [3:0]  PHASE_IDX;

  mod_phase_sequencer dut (
    .USER_CLOCK(clk), .RESET(RESET), .START(START), .ABORT(ABORT),
    .PHASE_START(PHASE_START), .PHASE_STEP(PHASE_STEP), .NUM_PHASES(NUM_PHASES),
    .DRAIN_CYCLES(DRAIN_CYCLES), .EXPOSE_CYCLES(EXPOSE_CYCLES),
    .READOUT_CYCLES(READOUT_CYCLES), .FREQ_REQ(FREQ_REQ), .DUTY_REQ(DUTY_REQ),
    .FREQ_SEL(FREQ_SEL), .PHASE_SEL(PHASE_SEL), .DUTY_SEL(DUTY_SEL),
    .DRAIN_B(DRAIN_B), .MOD_EN(MOD_EN), .READOUT_REQ(READOUT_REQ),
    .BUSY(BUSY), .DONE(DONE), .PHASE_IDX(PHASE_IDX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  num;
    logic [4:0]  ps;
    logic [4:0]  st;
    logic [15:0] dr;
    logic [23:0] ex;
    logic [15:0] ro;
    logic [2:0]  fr;
    logic [3:0]  du;
  } cfg_t;

  typedef struct packed {
    logic [2:0] freq;
    logic [4:0] phase;
    logic [3:0] duty;
    logic       drain_b;
    logic       mod_en;
    logic       ro;
    logic       busy;
    logic       done;
    logic [3:0] idx;
  } out_t;

  typedef struct {
    cfg_t       c;
    int         busy;
    logic [4:0] ph;
    logic [2:0] fr;
    logic [3:0] du;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  out_t exp_q[$];
  out_t idle_exp;

  function automatic cfg_t mk_cfg(int num, int ps, int st, int dr, int ex, int ro, int fr, int du);
    cfg_t c;
    c.num = 4'(num); c.ps = 5'(ps); c.st = 5'(st);
    c.dr = 16'(dr); c.ex = 24'(ex); c.ro = 16'(ro);
    c.fr = 3'(fr); c.du = 4'(du);
    return c;
  endfunction

  function automatic cfg_t rand_cfg();
    return mk_cfg($urandom_range(0, 5), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 4),
                  $urandom_range(0, 7), $urandom_range(0, 15));
  endfunction

  function automatic int trace_len(cfg_t c);
    int n, d, e, r;
    n = (c.num == 0) ? 1 : int'(c.num);
    d = (c.dr == 0) ? 1 : int'(c.dr);
    e = (c.ex == 0) ? 1 : int'(c.ex);
    r = (c.ro == 0) ? 1 : int'(c.ro);
    return n * (d + e + r) + 1;
  endfunction

  // Expected output per cycle after START: each step is d drained, e modulating,
  // r readout cycles; one DONE cycle closes the capture.
  function automatic void build_trace(cfg_t c);
    int   n, d, e, r;
    out_t o;
    exp_q.delete();
    n = (c.num == 0) ? 1 : int'(c.num);
    d = (c.dr == 0) ? 1 : int'(c.dr);
    e = (c.ex == 0) ? 1 : int'(c.ex);
    r = (c.ro == 0) ? 1 : int'(c.ro);
    o = '0;
    o.freq = (c.fr > 3'd5) ? 3'd5 : c.fr;
    o.duty = c.du;
    for (int i = 0; i < n; i++) begin
      o.phase = 5'((int'(c.ps) + i * int'(c.st)) % 32);
      o.idx   = 4'(i);
      o.busy  = 1'b1;
      o.done  = 1'b0;
      for (int k = 0; k < d; k++) begin
        o.drain_b = 1'b0; o.mod_en = 1'b0; o.ro = 1'b0; exp_q.push_back(o);
      end
      for (int k = 0; k < e; k++) begin
        o.drain_b = 1'b1; o.mod_en = 1'b1; o.ro = 1'b0; exp_q.push_back(o);
      end
      for (int k = 0; k < r; k++) begin
        o.drain_b = 1'b1; o.mod_en = 1'b0; o.ro = 1'b1; exp_q.push_back(o);
      end
    end
    o.busy = 1'b0; o.done = 1'b1; o.drain_b = 1'b0; o.mod_en = 1'b0; o.ro = 1'b0;
    exp_q.push_back(o);
  endfunction

  function automatic out_t sample();
    return {FREQ_SEL, PHASE_SEL, DUTY_SEL, DRAIN_B, MOD_EN, READOUT_REQ, BUSY, DONE, PHASE_IDX};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic drive_cfg(input cfg_t c);
    NUM_PHASES = c.num; PHASE_START = c.ps; PHASE_STEP = c.st;
    DRAIN_CYCLES = c.dr; EXPOSE_CYCLES = c.ex; READOUT_CYCLES = c.ro;
    FREQ_REQ = c.fr; DUTY_REQ = c.du;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle", 32'(sample()), 32'(idle_exp));
      drive_cfg(rand_cfg());
      ABORT = 1'($urandom_range(0, 1));
    end
    ABORT = 1'b0;
  endtask

  // Called just after a negedge. stop_kind: 0 none, 1 ABORT, 2 RESET+START at record stop_at.
  task automatic run_capture(input cfg_t c, input bit scramble, input int stop_at,
                             input int stop_kind, output int busy_cnt, output out_t last);
    out_t o, e;
    int   len;
    build_trace(c);
    len = exp_q.size();
    drive_cfg(c);
    ABORT = 1'b0;
    START = 1'b1;
    busy_cnt = 0;
    last = '0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      START = 1'b0;
      o = sample();
      chk("trace", 32'(o), 32'(exp_q[k]));
      if (o.busy) busy_cnt++;
      last = o;
      if (stop_kind != 0 && k == stop_at) begin
        if (stop_kind == 1) begin
          e = exp_q[k];
          e.busy = 1'b0; e.mod_en = 1'b0; e.ro = 1'b0; e.drain_b = 1'b0; e.done = 1'b0;
          ABORT = 1'b1;
        end else begin
          e = '0;
          RESET = 1'b1;
          START = 1'b1;
        end
        @(negedge clk);
        chk(stop_kind == 1 ? "abort" : "reset", 32'(sample()), 32'(e));
        ABORT = 1'b0; RESET = 1'b0; START = 1'b0;
        @(negedge clk);
        chk("after_stop", 32'(sample()), 32'(e));
        idle_exp = e;
        return;
      end
      if (scramble) begin
        drive_cfg(rand_cfg());
        START = (k < len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    START = 1'b0;
    idle_exp = exp_q[len - 1];
    idle_exp.done = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(sample()), 32'(idle_exp));
  endtask

  vec_t tab[4];

  initial begin
    int   bc;
    out_t last;
    cfg_t c;
    int   kind;

    tab[0].c = mk_cfg(4, 0, 8, 3, 10, 5, 1, 3);   tab[0].busy = 72; tab[0].ph = 5'd24; tab[0].fr = 3'd1; tab[0].du = 4'd3;
    tab[1].c = mk_cfg(3, 28, 8, 1, 2, 1, 7, 14);  tab[1].busy = 12; tab[1].ph = 5'd12; tab[1].fr = 3'd5; tab[1].du = 4'd14;
    tab[2].c = mk_cfg(0, 7, 3, 0, 0, 0, 5, 0);    tab[2].busy = 3;  tab[2].ph = 5'd7;  tab[2].fr = 3'd5; tab[2].du = 4'd0;
    tab[3].c = mk_cfg(2, 31, 1, 2, 1, 0, 0, 15);  tab[3].busy = 8;  tab[3].ph = 5'd0;  tab[3].fr = 3'd0; tab[3].du = 4'd15;

    RESET = 1'b1; START = 1'b0; ABORT = 1'b0;
    drive_cfg('0);
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(sample()), 32'd0);
    RESET = 1'b0;
    idle_exp = '0;
    idle_cycles(2);

    for (int i = 0; i < 4; i++) begin
      run_capture(tab[i].c, 1'b0, -1, 0, bc, last);
      chk("busy_cycles", 32'(bc), 32'(tab[i].busy));
      chk("final_phase", 32'(last.phase), 32'(tab[i].ph));
      chk("freq_sel", 32'(last.freq), 32'(tab[i].fr));
      chk("duty_sel", 32'(last.duty), 32'(tab[i].du));
      chk("done_flag", 32'(last.done), 32'd1);
      idle_cycles(2);
    end

    // Inputs and stray STARTs scrambled throughout the capture; clamp stays at 5.
    run_capture(mk_cfg(3, 5, 9, 2, 4, 2, 7, 14), 1'b1, -1, 0, bc, last);
    chk("frozen_freq", 32'(last.freq), 32'd5);
    idle_cycles(1);

    // ABORT in the middle of step 1 EXPOSE, then a fresh capture from PHASE_START.
    run_capture(tab[0].c, 1'b1, 25, 1, bc, last);
    chk("abort_phase", 32'(idle_exp.phase), 32'd8);
    idle_cycles(2);
    run_capture(tab[0].c, 1'b0, -1, 0, bc, last);
    chk("restart_busy", 32'(bc), 32'd72);
    idle_cycles(1);

    // RESET with START during step 0 READOUT.
    run_capture(tab[0].c, 1'b0, 14, 2, bc, last);
    idle_cycles(1);

    // START together with ABORT in IDLE does nothing.
    START = 1'b1; ABORT = 1'b1;
    @(negedge clk);
    chk("start_abort_idle", 32'(sample()), 32'(idle_exp));
    START = 1'b0; ABORT = 1'b0;
    @(negedge clk);
    chk("start_abort_idle2", 32'(sample()), 32'(idle_exp));

    for (int i = 0; i < 30; i++) begin
      c = rand_cfg();
      kind = ($urandom_range(0, 7) == 0) ? 2 : (($urandom_range(0, 3) == 0) ? 1 : 0);
      run_capture(c, 1'($urandom_range(0, 1)), $urandom_range(0, trace_len(c) - 1), kind, bc, last);
      idle_cycles($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_phase_sequencer.md
Name: mod_phase_sequencer

Overview:
- Upstream controller for mod_signal_gen: generates FREQ_SEL, PHASE_SEL, DUTY_SEL and DRAIN_B so the modulated-clock generator runs a multi-phase time-of-flight capture without host involvement.
- Per capture: loops over NUM_PHASES phase steps. Each step runs DRAIN, then EXPOSE (modulation on), then READOUT (request to readout logic).
- Host (OK board) supplies configuration and a START pulse; the block reports BUSY, DONE and the current phase index.

Parameters:
- CNT_W, 24, width of the exposure counter and EXPOSE_CYCLES.
- AUX_W, 16, width of DRAIN_CYCLES and READOUT_CYCLES.
- FREQ_MAX, 5, highest legal FREQ_SEL code; larger requests are clamped to it.

Ports:
- USER_CLOCK  in  1  sole clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle capture request; honoured only in IDLE.
- ABORT  in  1  cancels the capture; wins over START.
- PHASE_START  in  5  PHASE_SEL for step 0.
- PHASE_STEP  in  5  PHASE_SEL increment per step, modulo 32.
- NUM_PHASES  in  4  steps per capture; 0 is treated as 1.
- DRAIN_CYCLES  in  AUX_W  drain length in clocks; 0 is treated as 1.
- EXPOSE_CYCLES  in  CNT_W  exposure length in clocks; 0 is treated as 1.
- READOUT_CYCLES  in  AUX_W  readout window in clocks; 0 is treated as 1.
- FREQ_REQ  in  3  requested frequency code.
- DUTY_REQ  in  4  requested duty code.
- FREQ_SEL  out  3  to mod_signal_gen.
- PHASE_SEL  out  5  to mod_signal_gen.
- DUTY_SEL  out  4  to mod_signal_gen.
- DRAIN_B  out  1  pixel drain, active low.
- MOD_EN  out  1  high during EXPOSE; gates the light source downstream.
- READOUT_REQ  out  1  high during READOUT.
- BUSY  out  1  high in any non-IDLE state.
- DONE  out  1  one-cycle pulse when the capture completes normally.
- PHASE_IDX  out  4  current step index.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, FREQ_SEL=0, PHASE_SEL=0, DUTY_SEL=0, DRAIN_B=0 (pixels held drained), MOD_EN=0, READOUT_REQ=0, BUSY=0, DONE=0, PHASE_IDX=0, all counters 0.
- States: IDLE, DRAIN, EXPOSE, READOUT.
- IDLE + START (ABORT low) at edge t:
  - latch the config;
  - FREQ_SEL = min(FREQ_REQ, FREQ_MAX); DUTY_SEL = DUTY_REQ; PHASE_SEL = PHASE_START; PHASE_IDX = 0;
  - from cycle t+1: state=DRAIN, BUSY=1, DRAIN_B=0.
- Latched config (NUM_PHASES, counts, PHASE_STEP, FREQ_SEL, DUTY_SEL) is frozen for the whole capture; input changes while BUSY have no effect.
- DRAIN: DRAIN_B=0, MOD_EN=0, READOUT_REQ=0; lasts exactly max(DRAIN_CYCLES,1) cycles, then EXPOSE.
- PHASE_SEL is only updated on entry to DRAIN, so the downstream counter generator re-aligns before modulation starts.
- EXPOSE: DRAIN_B=1, MOD_EN=1; lasts exactly max(EXPOSE_CYCLES,1) cycles, then READOUT.
- READOUT: DRAIN_B=1, MOD_EN=0, READOUT_REQ=1; lasts exactly max(READOUT_CYCLES,1) cycles.
- End of READOUT:
  - if PHASE_IDX == max(NUM_PHASES,1)-1: go to IDLE, DONE=1 for one cycle (coincident with BUSY falling to 0), DRAIN_B=0;
  - else: PHASE_IDX+1, PHASE_SEL = (PHASE_SEL+PHASE_STEP) mod 32 (wraps, e.g. 28+8 gives 4), go to DRAIN.
- FREQ_SEL, DUTY_SEL and PHASE_SEL hold their last values in IDLE.
- ABORT high in any state: next cycle IDLE, MOD_EN=0, READOUT_REQ=0, DRAIN_B=0, BUSY=0, no DONE. PHASE_IDX and PHASE_SEL hold.
- START while BUSY: ignored, not queued.
- START and ABORT together in IDLE: ignored.
- RESET mid-capture: returns to reset values on the next edge.
- MOD_EN and READOUT_REQ are never high in the same cycle.
- DRAIN_B is never high when MOD_EN has just fallen with the state in IDLE.

Test Plan:
- Reset, NUM_PHASES=4, PHASE_START=0, PHASE_STEP=8, DRAIN=3, EXPOSE=10, READOUT=5, pulse START -> PHASE_SEL sequence 0,8,16,24; each step is 3 DRAIN_B-low, 10 MOD_EN, 5 READOUT_REQ cycles; DONE one cycle after the 72nd busy cycle; BUSY high for exactly 72 cycles.
- PHASE_START=28, PHASE_STEP=8, NUM_PHASES=3 -> PHASE_SEL 28, 4, 12 (wrap); PHASE_IDX 0, 1, 2.
- NUM_PHASES=0 and all cycle counts 0 -> one step of 1+1+1 cycles, DONE asserted, BUSY high 3 cycles.
- FREQ_REQ=7, DUTY_REQ=14 -> FREQ_SEL=5, DUTY_SEL=14; changing FREQ_REQ to 2 mid-capture leaves FREQ_SEL=5.
- ABORT during EXPOSE of step 1 -> next cycle MOD_EN=0, BUSY=0, DRAIN_B=0, no DONE; a START during the capture is ignored, and a new START afterwards restarts from PHASE_START.
- RESET asserted during READOUT -> all outputs at their reset values after one edge; START in the same cycle as RESET has no effect.
